// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single add/sub controller (cmp, align, add, norm, pack).
// Define FP_SPECIAL_EN to route NaN/infinity operands from CMP straight to PACK.
module fp_add_sequencer #(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23,
  parameter int ALIGN_LIMIT = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   op_a,
  input  logic [EXP_W+MANT_W:0]   op_b,
  input  logic                    op_sel,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    overflow,
  output logic                    neg
);
  localparam int W = EXP_W + MANT_W + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] LIM = EXP_W'(ALIGN_LIMIT);
  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, PACK} state_t;
  state_t state;
  logic [W-1:0] a, b;
  logic sub_op, sign, eff_sub, uflow;
  logic [MANT_W:0] big_m, small_m, ma, mb;
  logic [MANT_W+1:0] sum, sum_n;
  logic [EXP_W:0] exp_r;
  logic [EXP_W-1:0] cnt, ea, eb, e_big, e_small, diff;
  logic sa, sb, a_big;
`ifdef FP_SPECIAL_EN
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};
  logic special, nan_case;
  logic [W-1:0] spec_res;
  assign nan_case = (ea == EMAX && a[MANT_W-1:0] != '0) || (eb == EMAX && b[MANT_W-1:0] != '0) ||
                    (ea == EMAX && eb == EMAX && sa != sb);
`endif
  always_comb begin
    ea = a[W-2:MANT_W];
    eb = b[W-2:MANT_W];
    ma = (ea != '0) ? {1'b1, a[MANT_W-1:0]} : '0;
    mb = (eb != '0) ? {1'b1, b[MANT_W-1:0]} : '0;
    sa = a[W-1];
    sb = b[W-1] ^ sub_op;
    a_big = {ea, ma} >= {eb, mb};
    e_big = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    diff = e_big - e_small;
    sum_n = eff_sub ? {1'b0, big_m} - {1'b0, small_m} : {1'b0, big_m} + {1'b0, small_m};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      neg <= 1'b0;
      result <= '0;
      a <= '0;
      b <= '0;
      sub_op <= 1'b0;
      sign <= 1'b0;
      eff_sub <= 1'b0;
      uflow <= 1'b0;
      big_m <= '0;
      small_m <= '0;
      sum <= '0;
      exp_r <= '0;
      cnt <= '0;
`ifdef FP_SPECIAL_EN
      special <= 1'b0;
      spec_res <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= op_a;
          b <= op_b;
          sub_op <= op_sel;
          busy <= 1'b1;
          overflow <= 1'b0;
          neg <= 1'b0;
          uflow <= 1'b0;
`ifdef FP_SPECIAL_EN
          special <= 1'b0;
`endif
          state <= CMP;
        end
        CMP: begin
          big_m <= a_big ? ma : mb;
          small_m <= (diff >= LIM) ? '0 : (a_big ? mb : ma);
          exp_r <= {1'b0, e_big};
          sign <= a_big ? sa : sb;
          eff_sub <= sa ^ sb;
          cnt <= (diff >= LIM) ? EXP_W'(1) : diff;
`ifdef FP_SPECIAL_EN
          if (ea == EMAX || eb == EMAX) begin
            special <= 1'b1;
            spec_res <= nan_case ? QNAN : {(ea == EMAX) ? sa : sb, EMAX, {MANT_W{1'b0}}};
            state <= PACK;
          end else
`endif
          state <= (diff == '0) ? ADD : ALIGN;
        end
        ALIGN: begin
          small_m <= small_m >> 1;
          cnt <= cnt - 1'b1;
          if (cnt == EXP_W'(1)) state <= ADD;
        end
        ADD: begin
          sum <= sum_n;
          state <= (sum_n == '0 || (!sum_n[MANT_W+1] && sum_n[MANT_W])) ? PACK : NORM;
        end
        NORM: begin
          if (sum[MANT_W+1]) begin
            sum <= sum >> 1;
            exp_r <= exp_r + 1'b1;
            state <= PACK;
          end else if (exp_r == {{EXP_W{1'b0}}, 1'b1}) begin
            uflow <= 1'b1;
            state <= PACK;
          end else begin
            sum <= sum << 1;
            exp_r <= exp_r - 1'b1;
            if (sum[MANT_W-1]) state <= PACK;
          end
        end
        PACK: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
`ifdef FP_SPECIAL_EN
          if (special) begin
            result <= spec_res;
            neg <= spec_res[W-1];
          end else
`endif
          if (sum == '0 || uflow) begin
            result <= '0;
            neg <= 1'b0;
          end else if (exp_r >= {1'b0, EMAX}) begin
            overflow <= 1'b1;
            result <= {sign, EMAX, {MANT_W{1'b0}}};
            neg <= sign;
          end else begin
            result <= {sign, exp_r[EXP_W-1:0], sum[MANT_W-1:0]};
            neg <= sign;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
Multi-cycle controller for the single-precision floating-point add/subtract path. It sequences the four datapath phases in order: exponent compare, mantissa alignment shift, add/sub, and normalize. A final pack phase assembles the IEEE-754 result. One operation is in flight at a time, with a start/busy/done handshake toward the issuing logic.

Parameters:
EXP_W, 8, exponent width
MANT_W, 23, stored mantissa width (hidden bit implicit)
ALIGN_LIMIT, 26, exponent difference at or above which the smaller mantissa is cleared in one cycle

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only while busy=0
op_a  input  32  operand A, IEEE-754 single
op_b  input  32  operand B, IEEE-754 single
op_sel  input  1  0 = A+B, 1 = A-B
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result and flags valid from this cycle until the next accept
result  output  32  packed result
overflow  output  1  result exponent saturated to all-ones
neg  output  1  sign bit of result

Behaviour:
- One clock. Reset is synchronous and active-high; names are clk/reset. On reset: state=IDLE; busy, done, overflow, neg=0; result=0. Reset mid-operation aborts the operation with no done pulse.
- Accept: start=1 in IDLE latches op_a, op_b and op_sel. start while busy=1 is ignored and not queued.
- Effective B sign = sign_b XOR op_sel.
- Exponent 0 means the input is treated as zero, including its mantissa (denormals flushed).
- States:
  - IDLE.
  - CMP, 1 cycle. Orders operands by magnitude (exponent, then mantissa) and computes diff = exp_big - exp_small.
  - ALIGN, d cycles. Right-shifts the small mantissa 1 bit per cycle, with d = diff. If diff >= ALIGN_LIMIT, the mantissa is cleared and d=1. If diff=0, ALIGN is skipped.
  - ADD, 1 cycle. 25-bit add if signs are equal; otherwise big - small, never negative.
  - NORM, k cycles. On carry: shift right 1 and exp+1, so k=1. Otherwise shift left 1 and exp-1 per cycle until bit MANT_W is set. A zero sum skips NORM, so k=0.
  - PACK, 1 cycle. Registers result, neg and overflow, pulses done, then returns to IDLE.
- Latency: done is high 3+d+k cycles after the accepting edge.
- Rounding: truncation. Shifted-out bits are discarded; there are no guard bits.
- Result sign = sign of the larger-magnitude operand.
- Exact zero gives +0 (0x00000000), neg=0.
- If the exponent reaches 255 after NORM: overflow=1 and result = signed infinity (mantissa 0).
- If the exponent would drop below 1 during NORM: NORM stops and result=+0.
- overflow and neg hold until the next accepted start, then clear.

Optional Feature:
Macro FP_SPECIAL_EN.
- Defined: CMP detects exponent-255 inputs and jumps directly to PACK, so latency is 2.
  - Any NaN gives 0x7FC00000.
  - inf ± inf with differing effective signs gives 0x7FC00000.
  - Otherwise the result is the infinity operand with its effective sign.
  - overflow=0 in all these cases.
- Undefined: exponent 255 is treated as a finite value and flows through the normal path.

Test Plan:
1. 0x3F800000 + 0x3F800000, op_sel=0 -> done at cycle 4, result 0x40000000, overflow=0, neg=0.
2. 0x40400000 - 0x3F800000, op_sel=1 -> d=1, k=0, done at cycle 4, result 0x40000000.
3. 0x3F800000 - 0x3F800000 -> done at cycle 3, result 0x00000000, neg=0. Also 0x3F800000 + 0x30800000 -> diff 30, d=1, done at cycle 4, result 0x3F800000.
4. 0x7F7FFFFF + 0x7F7FFFFF -> carry, done at cycle 4, result 0x7F800000, overflow=1. 0xBF800000 + 0x3F000000 -> result 0xBF000000, neg=1.
5. reset during ALIGN of 1.0 + 2^-20 -> next cycle busy=0, done=0, result=0, and no done pulse follows. start pulsed while busy -> ignored, exactly one done.
6. FP_SPECIAL_EN defined: 0x7F800000 - 0x7F800000 -> done at cycle 2, result 0x7FC00000. Undefined: same stimulus completes through the normal path with no special handling.
